alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue stage placed directly in front of the ALU: accepts a decoded instruction (ALUOp, funct, two register operands) over a valid/ready handshake and registers the operands. Translates ALUOp and funct into the ALU's 4-bit control code and presents operands plus code to the ALU as one registered beat. Multiply is held stable for a programmable number of cycles before the beat is declared valid, so the ALU's long multiply path is a multicycle path. Sits between the ID/EX pipeline register logic and the ALU / EX writeback consumer.

## Interface
- MUL_LAT, 3, cycles operands/code are held before a multiply beat goes valid; legal range 1..15
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  upstream beat valid
- in_ready_o  out  1  block can accept a beat this cycle
- alu_op_i  in  3  ALUOp from main decoder
- funct_i  in  6  R-type funct field
- rs_data_i  in  32  first operand
- rt_data_i  in  32  second operand
- out_valid_o  out  1  ALU beat valid
- out_ready_i  in  1  downstream consumes beat
- src1_o  out  32  to ALU src1
- src2_o  out  32  to ALU src2
- ctrl_o  out  4  to ALU ctrl
- illegal_o  out  1  current beat has unsupported encoding
- busy_o  out  1  multiply wait in progress

## Operation
- Decode, ALUOp 000 -> 0010 (add); 001 -> 0110 (sub); 011 -> 0001 (or); 100 -> 0111 (slt); 010 -> by funct.
- funct: 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 011000 -> 0011 (mul, macro-gated).
- Any other ALUOp/funct: ctrl_o = 1111 (ALU yields 0), illegal_o = 1; beat still flows through handshake normally.
- Transfer in: in_valid_i && in_ready_o at a rising edge. Transfer out: out_valid_o && out_ready_i.
- States: IDLE, MWAIT, VALID.
  - IDLE: in_ready_o = 1, out_valid_o = 0. On transfer in: mul -> MWAIT, counter = MUL_LAT-1; else -> VALID.
  - MWAIT: in_ready_o = 0, busy_o = 1, out_valid_o = 0; counter decrements; at 0 -> VALID.
  - VALID: out_valid_o = 1, in_ready_o = out_ready_i. Transfer out with no transfer in -> IDLE; transfer out and transfer in -> loads new beat, next state as from IDLE; no transfer out -> hold.
- src1_o/src2_o/ctrl_o/illegal_o load only on transfer in; stable in MWAIT and while VALID stalled.
- No arithmetic on operands; counter width 4 bits.

## Timing
- Reset (rst_i low, asynchronous): state IDLE, out_valid_o 0, in_ready_o 1, busy_o 0, src1_o/src2_o 0, ctrl_o 0000, illegal_o 0, counter 0.
- Reset mid-MWAIT or mid-VALID: beat discarded, no output transfer.
- Non-mul accepted at edge N: out_valid_o high after edge N.
- Mul accepted at edge N: busy_o high for MUL_LAT cycles, out_valid_o high after edge N+MUL_LAT.
- in_ready_o is combinational from state and out_ready_i; full throughput 1 beat/cycle for non-mul streams.
- in_valid_i while in_ready_o = 0: no effect; upstream must hold.

## Configuration
- ALU_ISSUE_MUL_EN defined: funct 011000 decodes to 0011 and uses MWAIT.
- Undefined: funct 011000 is illegal (1111, illegal_o = 1); MWAIT, counter, busy_o logic removed; busy_o tied 0; MUL_LAT ignored.

## Structure
- Package alu_issue_pkg: ALUOp constants, funct constants, ctrl codes (CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_MUL, CTRL_SUB, CTRL_SLT, CTRL_ILLEGAL), state encoding.
- Sub-module alu_op_decode: combinational ALUOp/funct -> {ctrl, illegal, is_mul}; instanced once on input side.

## Test plan
- Reset then ALUOp 010, funct 100000, rs 5, rt 7, out_ready_i 1 -> next cycle out_valid_o 1, ctrl_o 0010, src1_o 5, src2_o 7, illegal_o 0.
- Back-to-back and/or/slt beats with out_ready_i 1 -> one output per cycle, ctrl 0000, 0001, 0111 in order, in_ready_o stays 1.
- Mul 3 x 4 with MUL_LAT 3 (macro on) -> busy_o 1 for 3 cycles, in_ready_o 0, then out_valid_o 1 with ctrl 0011; macro off -> ctrl 1111, illegal_o 1 next cycle.
- ALUOp 010 funct 000000 -> ctrl_o 1111, illegal_o 1, handshake completes normally.
- out_ready_i 0 for 4 cycles after a sub beat -> outputs and ctrl 0110 frozen, in_ready_o 0; release -> single transfer.
- rst_i asserted mid-MWAIT -> outputs immediately to reset values, no out_valid_o pulse afterwards.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: ALUOp/funct fields, ALU control codes, FSM states.
package alu_issue_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_MUL     = 4'b0011;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_SLT     = 4'b0111;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MWAIT = 2'd1,
    ST_VALID = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct -> ALU control code translation with illegal flag.
// Multiply decode (and the o_is_mul port) exists only when ALU_ISSUE_MUL_EN is defined.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [2:0] i_alu_op,
  input  logic [5:0] i_funct,
`ifdef ALU_ISSUE_MUL_EN
  output logic       o_is_mul,
`endif
  output logic [3:0] o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_ILLEGAL;
    o_illegal = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
    o_is_mul  = 1'b0;
`endif
    case (i_alu_op)
      ALUOP_ADD: begin o_ctrl = CTRL_ADD; o_illegal = 1'b0; end
      ALUOP_SUB: begin o_ctrl = CTRL_SUB; o_illegal = 1'b0; end
      ALUOP_OR:  begin o_ctrl = CTRL_OR;  o_illegal = 1'b0; end
      ALUOP_SLT: begin o_ctrl = CTRL_SLT; o_illegal = 1'b0; end
      ALUOP_RTYPE: begin
        case (i_funct)
          FUNCT_ADD: begin o_ctrl = CTRL_ADD; o_illegal = 1'b0; end
          FUNCT_SUB: begin o_ctrl = CTRL_SUB; o_illegal = 1'b0; end
          FUNCT_AND: begin o_ctrl = CTRL_AND; o_illegal = 1'b0; end
          FUNCT_OR:  begin o_ctrl = CTRL_OR;  o_illegal = 1'b0; end
          FUNCT_SLT: begin o_ctrl = CTRL_SLT; o_illegal = 1'b0; end
`ifdef ALU_ISSUE_MUL_EN
          FUNCT_MUL: begin o_ctrl = CTRL_MUL; o_illegal = 1'b0; o_is_mul = 1'b1; end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue stage: registers one decoded beat and presents it to the ALU over valid/ready.
// With ALU_ISSUE_MUL_EN defined, multiply beats are held MUL_LAT cycles (busy_o) before going valid.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  alu_op_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [3:0]  ctrl_o,
  output logic        illegal_o,
  output logic        busy_o
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("alu_issue_ctrl: MUL_LAT must be in 1..15");
  end

  state_t      r_state, w_state_nxt;
  logic [31:0] r_src1, r_src2;
  logic [3:0]  r_ctrl;
  logic        r_illegal;
  logic [3:0]  w_dec_ctrl;
  logic        w_dec_illegal;
  logic        w_xfer_in;

`ifdef ALU_ISSUE_MUL_EN
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);
  logic       w_dec_is_mul;
  logic [3:0] r_cnt, w_cnt_nxt;
`endif

  alu_op_decode u_dec (
    .i_alu_op  (alu_op_i),
    .i_funct   (funct_i),
`ifdef ALU_ISSUE_MUL_EN
    .o_is_mul  (w_dec_is_mul),
`endif
    .o_ctrl    (w_dec_ctrl),
    .o_illegal (w_dec_illegal)
  );

  // A valid beat can be replaced in the same cycle it drains.
  assign in_ready_o  = (r_state == ST_IDLE) || ((r_state == ST_VALID) && out_ready_i);
  assign out_valid_o = (r_state == ST_VALID);
  assign w_xfer_in   = in_valid_i && in_ready_o;

  always_comb begin
    w_state_nxt = r_state;
`ifdef ALU_ISSUE_MUL_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      ST_IDLE: ;
      ST_VALID: if (out_ready_i) w_state_nxt = ST_IDLE;
`ifdef ALU_ISSUE_MUL_EN
      ST_MWAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_VALID;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_xfer_in) begin
      w_state_nxt = ST_VALID;
`ifdef ALU_ISSUE_MUL_EN
      if (w_dec_is_mul) begin
        w_state_nxt = ST_MWAIT;
        w_cnt_nxt   = CNT_INIT;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_src1    <= '0;
      r_src2    <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer_in) begin
        r_src1    <= rs_data_i;
        r_src2    <= rt_data_i;
        r_ctrl    <= w_dec_ctrl;
        r_illegal <= w_dec_illegal;
      end
    end
  end

`ifdef ALU_ISSUE_MUL_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  assign busy_o = (r_state == ST_MWAIT);
`else
  assign busy_o = 1'b0;
`endif

  assign src1_o    = r_src1;
  assign src2_o    = r_src2;
  assign ctrl_o    = r_ctrl;
  assign illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl; follows ALU_ISSUE_MUL_EN for the multiply scenarios.
module tb_alu_issue_ctrl;

  localparam int MUL_LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  alu_op_i = '0;
  logic [5:0]  funct_i = '0;
  logic [31:0] rs_data_i = '0;
  logic [31:0] rt_data_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [31:0] src1_o, src2_o;
  logic [3:0]  ctrl_o;
  logic        illegal_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_op_i(alu_op_i), .funct_i(funct_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .src1_o(src1_o), .src2_o(src2_o),
    .ctrl_o(ctrl_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference decode straight from the opcode table: {is_mul, illegal, ctrl}
  function automatic logic [5:0] ref_dec(input logic [2:0] op, input logic [5:0] fn);
    logic [5:0] r;
    r = 6'b01_1111;
    case (op)
      3'b000: r = 6'b00_0010;
      3'b001: r = 6'b00_0110;
      3'b011: r = 6'b00_0001;
      3'b100: r = 6'b00_0111;
      3'b010: begin
        case (fn)
          6'b100000: r = 6'b00_0010;
          6'b100010: r = 6'b00_0110;
          6'b100100: r = 6'b00_0000;
          6'b100101: r = 6'b00_0001;
          6'b101010: r = 6'b00_0111;
`ifdef ALU_ISSUE_MUL_EN
          6'b011000: r = 6'b10_0011;
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic ordy);
    in_valid_i = v; alu_op_i = op; funct_i = fn;
    rs_data_i = a; rt_data_i = b; out_ready_i = ordy;
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(1'b1, 3'b000, 6'd0, 32'h1234, 32'h5678, 1'b1);
    @(negedge clk_i);
    tick();
    #1;
    n_cmp++;
    if ({out_valid_o, in_ready_o, busy_o, illegal_o, ctrl_o, src1_o, src2_o} !== {3'b010, 5'b0, 64'b0}) begin
      n_err++;
      $display("FAIL reset_state: v/r/b=%b%b%b ill=%b ctrl=%b s1=%h s2=%h, want 010 0 0000 0 0",
               out_valid_o, in_ready_o, busy_o, illegal_o, ctrl_o, src1_o, src2_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_add_basic();
    drive(1'b1, 3'b010, 6'b100000, 32'd5, 32'd7, 1'b1);
    #1;
    n_cmp++;
    if ({in_ready_o, out_valid_o} !== 2'b10) begin
      n_err++; $display("FAIL add_idle: ready/valid=%b%b want 10", in_ready_o, out_valid_o);
    end
    tick();
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    #1;
    n_cmp++;
    if ({out_valid_o, illegal_o, ctrl_o, src1_o, src2_o} !== {1'b1, 1'b0, 4'b0010, 32'd5, 32'd7}) begin
      n_err++;
      $display("FAIL add_beat: v=%b ill=%b ctrl=%b s1=%0d s2=%0d want 1 0 0010 5 7",
               out_valid_o, illegal_o, ctrl_o, src1_o, src2_o);
    end
    tick();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL add_drain: out_valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  fns [3];
    logic [3:0]  ctl [3];
    logic [31:0] av  [3];
    fns[0] = 6'b100100; fns[1] = 6'b100101; fns[2] = 6'b101010;
    ctl[0] = 4'b0000;   ctl[1] = 4'b0001;   ctl[2] = 4'b0111;
    for (int i = 0; i < 3; i++) av[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1'b1, 3'b010, fns[i], av[i], ~av[i], 1'b1);
      else       drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
      #1;
      n_cmp++;
      if (in_ready_o !== 1'b1) begin
        n_err++; $display("FAIL b2b_ready[%0d]: in_ready=%b want 1", i, in_ready_o);
      end
      if (i > 0) begin
        n_cmp++;
        if ({out_valid_o, ctrl_o, src1_o, src2_o} !== {1'b1, ctl[i-1], av[i-1], ~av[i-1]}) begin
          n_err++;
          $display("FAIL b2b_beat[%0d]: v=%b ctrl=%b s1=%h s2=%h want 1 %b %h %h",
                   i-1, out_valid_o, ctrl_o, src1_o, src2_o, ctl[i-1], av[i-1], ~av[i-1]);
        end
      end
      tick();
    end
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_mul();
    drive(1'b1, 3'b010, 6'b011000, 32'd3, 32'd4, 1'b1);
    tick();
`ifdef ALU_ISSUE_MUL_EN
    // A second beat waits upstream; it must not be taken during the multiply wait.
    drive(1'b1, 3'b000, 6'd0, 32'd9, 32'd9, 1'b1);
    for (int k = 0; k < MUL_LAT; k++) begin
      #1;
      n_cmp++;
      if ({busy_o, in_ready_o, out_valid_o, illegal_o, ctrl_o, src1_o, src2_o} !==
          {4'b1000, 4'b0011, 32'd3, 32'd4}) begin
        n_err++;
        $display("FAIL mul_wait[%0d]: b/r/v=%b%b%b ill=%b ctrl=%b s1=%0d s2=%0d want 100 0 0011 3 4",
                 k, busy_o, in_ready_o, out_valid_o, illegal_o, ctrl_o, src1_o, src2_o);
      end
      tick();
    end
    #1;
    n_cmp++;
    if ({busy_o, out_valid_o, in_ready_o, illegal_o, ctrl_o, src1_o, src2_o} !==
        {4'b0110, 4'b0011, 32'd3, 32'd4}) begin
      n_err++;
      $display("FAIL mul_valid: b/v/r=%b%b%b ill=%b ctrl=%b s1=%0d s2=%0d want 011 0 0011 3 4",
               busy_o, out_valid_o, in_ready_o, illegal_o, ctrl_o, src1_o, src2_o);
    end
    tick();
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    #1;
    n_cmp++;
    if ({out_valid_o, ctrl_o, src1_o, src2_o} !== {1'b1, 4'b0010, 32'd9, 32'd9}) begin
      n_err++;
      $display("FAIL mul_next: v=%b ctrl=%b s1=%0d s2=%0d want 1 0010 9 9",
               out_valid_o, ctrl_o, src1_o, src2_o);
    end
`else
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    #1;
    n_cmp++;
    if ({out_valid_o, busy_o, illegal_o, ctrl_o, src1_o, src2_o} !==
        {3'b101, 4'b1111, 32'd3, 32'd4}) begin
      n_err++;
      $display("FAIL mul_off: v/b=%b%b ill=%b ctrl=%b s1=%0d s2=%0d want 10 1 1111 3 4",
               out_valid_o, busy_o, illegal_o, ctrl_o, src1_o, src2_o);
    end
`endif
    tick();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL mul_drain: out_valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] a;
    a = $urandom;
    drive(1'b1, 3'b010, 6'b000000, a, 32'd1, 1'b1);
    tick();
    drive(1'b1, 3'b111, 6'b100000, 32'd2, a, 1'b1);
    #1;
    n_cmp++;
    if ({out_valid_o, in_ready_o, illegal_o, ctrl_o, src1_o} !== {3'b111, 4'b1111, a}) begin
      n_err++;
      $display("FAIL illegal_funct: v/r=%b%b ill=%b ctrl=%b s1=%h want 11 1 1111 %h",
               out_valid_o, in_ready_o, illegal_o, ctrl_o, src1_o, a);
    end
    tick();
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    #1;
    n_cmp++;
    if ({out_valid_o, illegal_o, ctrl_o, src2_o} !== {2'b11, 4'b1111, a}) begin
      n_err++;
      $display("FAIL illegal_aluop: v=%b ill=%b ctrl=%b s2=%h want 1 1 1111 %h",
               out_valid_o, illegal_o, ctrl_o, src2_o, a);
    end
    tick();
    n_cmp++;
    if (out_valid_o !== 1'b0) begin
      n_err++; $display("FAIL illegal_drain: out_valid=%b want 0", out_valid_o);
    end
  endtask

  task automatic test_stall();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    drive(1'b1, 3'b001, 6'd0, a, b, 1'b1);
    tick();
    drive(1'b1, 3'b000, 6'd0, b, a, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({out_valid_o, in_ready_o, ctrl_o, src1_o, src2_o} !== {2'b10, 4'b0110, a, b}) begin
        n_err++;
        $display("FAIL stall[%0d]: v/r=%b%b ctrl=%b s1=%h s2=%h want 10 0110 %h %h",
                 k, out_valid_o, in_ready_o, ctrl_o, src1_o, src2_o, a, b);
      end
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid_o, in_ready_o, ctrl_o} !== {2'b11, 4'b0110}) begin
      n_err++;
      $display("FAIL stall_release: v/r=%b%b ctrl=%b want 11 0110", out_valid_o, in_ready_o, ctrl_o);
    end
    tick();
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    #1;
    n_cmp++;
    if ({out_valid_o, ctrl_o, src1_o, src2_o} !== {1'b1, 4'b0010, b, a}) begin
      n_err++;
      $display("FAIL stall_next: v=%b ctrl=%b s1=%h s2=%h want 1 0010 %h %h",
               out_valid_o, ctrl_o, src1_o, src2_o, b, a);
    end
    tick();
  endtask

  task automatic test_reset_mid();
`ifdef ALU_ISSUE_MUL_EN
    drive(1'b1, 3'b010, 6'b011000, 32'd6, 32'd8, 1'b1);
    tick();
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    tick();
    #1;
    n_cmp++;
    if (busy_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: busy=%b want 1", busy_o);
    end
`else
    drive(1'b1, 3'b001, 6'd0, 32'd6, 32'd8, 1'b0);
    tick();
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b0);
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: out_valid=%b want 1", out_valid_o);
    end
    out_ready_i = 1'b1;
`endif
    #1;
    rst_i = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid_o, in_ready_o, busy_o, illegal_o, ctrl_o, src1_o, src2_o} !== {3'b010, 5'b0, 64'b0}) begin
      n_err++;
      $display("FAIL rstmid_async: v/r/b=%b%b%b ill=%b ctrl=%b s1=%h s2=%h want 010 0 0000 0 0",
               out_valid_o, in_ready_o, busy_o, illegal_o, ctrl_o, src1_o, src2_o);
    end
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < MUL_LAT + 3; k++) begin
      #1;
      n_cmp++;
      if ({out_valid_o, busy_o} !== 2'b00) begin
        n_err++; $display("FAIL rstmid_after[%0d]: v/b=%b%b want 00", k, out_valid_o, busy_o);
      end
      tick();
    end
  endtask

  // Single-slot model: a beat is visible from its acceptance edge plus its latency until consumed.
  task automatic test_random_stream(input int n);
    int          cyc, m_rt, sel;
    bit          m_full, exp_ov, exp_ir, exp_busy;
    logic [31:0] m_a, m_b, a, b;
    logic [5:0]  m_dec, fn;
    logic [2:0]  op;
    logic        v, ordy;
    logic [5:0]  fn_tab [6];
    fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
    fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010; fn_tab[5] = 6'b011000;
    cyc = 0; m_rt = 0; m_full = 1'b0; m_a = '0; m_b = '0; m_dec = '0;
    for (int i = 0; i < n; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 9);
      fn   = 6'($urandom);
      op   = 3'b010;
      case (sel)
        0: op = 3'b000;
        1: op = 3'b001;
        2: op = 3'b011;
        3: op = 3'b100;
        8: op = 3'($urandom_range(5, 7));
        9: ;
        default: fn = fn_tab[$urandom_range(0, 5)];
      endcase
      a = $urandom; b = $urandom;
      drive(v, op, fn, a, b, ordy);
      #1;
      exp_ov   = m_full && (cyc >= m_rt);
      exp_ir   = !m_full || (exp_ov && ordy);
      exp_busy = m_full && m_dec[5] && (cyc < m_rt);
      n_cmp++;
      if ({out_valid_o, in_ready_o, busy_o} !== {exp_ov, exp_ir, exp_busy}) begin
        n_err++;
        $display("FAIL rand_hs[%0d]: v/r/b=%b%b%b want %b%b%b",
                 i, out_valid_o, in_ready_o, busy_o, exp_ov, exp_ir, exp_busy);
      end
      if (exp_ov) begin
        n_cmp++;
        if ({illegal_o, ctrl_o, src1_o, src2_o} !== {m_dec[4:0], m_a, m_b}) begin
          n_err++;
          $display("FAIL rand_beat[%0d]: ill=%b ctrl=%b s1=%h s2=%h want %b %b %h %h",
                   i, illegal_o, ctrl_o, src1_o, src2_o, m_dec[4], m_dec[3:0], m_a, m_b);
        end
      end
      if (exp_ov && ordy) m_full = 1'b0;
      if (v && exp_ir) begin
        m_full = 1'b1;
        m_a    = a;
        m_b    = b;
        m_dec  = ref_dec(op, fn);
        m_rt   = cyc + 1 + (m_dec[5] ? MUL_LAT : 0);
      end
      tick();
      cyc++;
    end
    drive(1'b0, 3'b000, 6'd0, 32'd0, 32'd0, 1'b1);
    for (int k = 0; k < MUL_LAT + 2; k++) tick();
    #1;
    n_cmp++;
    if ({out_valid_o, busy_o, in_ready_o} !== 3'b001) begin
      n_err++;
      $display("FAIL rand_drain: v/b/r=%b%b%b want 001", out_valid_o, busy_o, in_ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random_stream(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
